// File: rtl/ldm_port_arbiter.sv
// Round-robin arbiter that shares one LDM port among NREQ requesters, with optional
// locked bursts. Read data comes back one cycle after the grant, tagged to the winner.
module ldm_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int AWIDTH    = 10,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     ldm_en,
  output logic                     ldm_we,
  output logic [AWIDTH-1:0]        ldm_addr,
  output logic [DWIDTH-1:0]        ldm_din,
  input  logic [DWIDTH-1:0]        ldm_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic [7:0]        burst_cnt;
  logic              pend_rd;
  logic [IW-1:0]     pend_id;
  logic [DWIDTH-1:0] rdata_hold;

  logic              gnt_found;
  logic [IW-1:0]     gnt_idx;
  logic              accept;
  logic              gnt_we;
  logic              gnt_lock;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % NREQ);
  endfunction

  // Scan from the far end back toward rr_ptr so the closest valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (state == OWNED) begin
      gnt_found = req_valid[owner];
      gnt_idx   = owner;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
          gnt_found = 1'b1;
          gnt_idx   = wrap_idx(int'(rr_ptr) + k);
        end
      end
    end
  end

  assign accept   = rst_n && gnt_found;
  assign gnt_we   = req_we[gnt_idx];
  assign gnt_lock = req_lock[gnt_idx];

  assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign ldm_en    = accept;
  assign ldm_we    = accept && gnt_we;
  assign ldm_addr  = accept ? req_addr[gnt_idx*AWIDTH +: AWIDTH] : '0;
  assign ldm_din   = accept ? req_wdata[gnt_idx*DWIDTH +: DWIDTH] : '0;

  // The LDM output register already provides the cycle of latency, so data passes straight through.
  assign rsp_valid = pend_rd ? (NREQ'(1) << pend_id) : '0;
  assign rsp_rdata = pend_rd ? ldm_dout : rdata_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      pend_rd    <= 1'b0;
      pend_id    <= '0;
      rdata_hold <= '0;
    end else begin
      pend_rd <= accept && !gnt_we;
      if (accept) begin
        pend_id <= gnt_idx;
      end
      if (pend_rd) begin
        rdata_hold <= ldm_dout;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (gnt_lock && (MAX_BURST > 1)) begin
              state     <= OWNED;
              owner     <= gnt_idx;
              burst_cnt <= 8'd1;
            end else begin
              rr_ptr <= wrap_idx(int'(gnt_idx) + 1);
            end
          end
        end
        OWNED: begin
          if (accept) begin
            if (gnt_lock && (int'(burst_cnt) + 1 < MAX_BURST)) begin
              burst_cnt <= burst_cnt + 8'd1;
            end else begin
              state     <= IDLE;
              burst_cnt <= '0;
              rr_ptr    <= wrap_idx(int'(owner) + 1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
